// File: rtl/mult_seq_mac.sv
// mult_seq_mac
// Sequential unsigned multiply-accumulate engine built around one DxD digit
// multiplier. Each N-bit operand is split into K=N/D digits. One shifted
// digit partial product is added into the accumulator per cycle, so an
// operation takes K*K CALC cycles followed by one DONE cycle.
//
// Parameters:
//   N      operand width, a multiple of D
//   D      digit width of the internal multiplier
//   ACC_W  accumulator width, >= 2*N
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active low
//   start     request; only looked at in IDLE
//   acc_mode  sampled with start: 0 clears out/ovf first, 1 accumulates
//   a, b      operands, captured when start is accepted
//   out       accumulator register
//   busy      high in CALC and DONE
//   done      one-cycle pulse when out is final
//   ovf       sticky carry out of the accumulator MSB
module mult_seq_mac #(
    parameter int N     = 8,
    parameter int D     = 2,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [ACC_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] LAST_DIG = CW'(K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    // Datapath for the current digit pair (i_q, j_q)
    logic [D-1:0]     a_dig;
    logic [D-1:0]     b_dig;
    logic [2*D-1:0]   prod;
    logic [ACC_W-1:0] pp;
    logic [ACC_W:0]   sum;   // extra bit is the carry that feeds ovf

    assign a_dig = a_q[D*i_q +: D];
    assign b_dig = b_q[D*j_q +: D];
    assign prod  = a_dig * b_dig;
    // Zero-extend before shifting so high product bits are not lost.
    assign pp    = ACC_W'(prod) << (D * (int'(i_q) + int'(j_q)));
    assign sum   = {1'b0, out_q} + {1'b0, pp};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    a_d     = a;
                    b_d     = b;
                    i_d     = '0;
                    j_d     = '0;
                    if (!acc_mode) begin
                        out_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                out_d = sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    ovf_d = 1'b1;
                end
                // j is the inner digit counter, i the outer one.
                if (j_q == LAST_DIG) begin
                    j_d = '0;
                    if (i_q == LAST_DIG) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == S_CALC) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mult_seq_mac.sv
// Directed bench for mult_seq_mac with three instances:
//   u=0: N=4, D=2, ACC_W=8
//   u=1: N=8, D=2, ACC_W=20 (default)
//   u=2: N=8, D=2, ACC_W=16
module tb_mult_seq_mac;

    logic       clk;
    logic       rst;
    logic       st [3];
    logic       md [3];
    logic [7:0] aa [3];
    logic [7:0] bb [3];

    logic [7:0]  out0;
    logic [19:0] out1;
    logic [15:0] out2;
    logic [2:0]  busy_w, done_w, ovf_w;

    int n_chk = 0;
    int n_err = 0;

    mult_seq_mac #(.N(4), .D(2), .ACC_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .acc_mode(md[0]),
        .a(aa[0][3:0]), .b(bb[0][3:0]), .out(out0),
        .busy(busy_w[0]), .done(done_w[0]), .ovf(ovf_w[0])
    );

    mult_seq_mac u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .acc_mode(md[1]),
        .a(aa[1]), .b(bb[1]), .out(out1),
        .busy(busy_w[1]), .done(done_w[1]), .ovf(ovf_w[1])
    );

    mult_seq_mac #(.N(8), .D(2), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .acc_mode(md[2]),
        .a(aa[2]), .b(bb[2]), .out(out2),
        .busy(busy_w[2]), .done(done_w[2]), .ovf(ovf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_out(int u);
        case (u)
            0:       return {24'd0, out0};
            1:       return {12'd0, out1};
            default: return {16'd0, out2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation on instance u and watch it to completion.
    // lat    : negedge index (1 = first sample after the start edge) where done is first seen
    // busy_n : number of sampled cycles with busy high
    // done_n : number of sampled cycles with done high
    // With disturb set, start is pulsed with a=b=1 during CALC.
    task automatic run_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                          input logic m, input bit disturb,
                          output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        st[u] = 1'b1; md[u] = m; aa[u] = av; bb[u] = bv;
        @(posedge clk);
        @(negedge clk);
        st[u] = 1'b0;
        lat = 0; busy_n = 0; done_n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy_w[u]) busy_n++;
            if (done_w[u]) begin
                done_n++;
                if (lat == 0) lat = c;
            end
            if (!busy_w[u]) break;
            if (disturb && c == 2) begin
                st[u] = 1'b1; md[u] = 1'b1; aa[u] = 8'd1; bb[u] = 8'd1;
            end
            if (disturb && c == 3) st[u] = 1'b0;
            @(negedge clk);
        end
    endtask

    int lat, bn, dn;

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            st[u] = 1'b0; md[u] = 1'b0; aa[u] = 8'd0; bb[u] = 8'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out1", get_out(1), 0);
        chk("rst_busy", {29'd0, busy_w}, 0);
        chk("rst_done", {29'd0, done_w}, 0);
        chk("rst_ovf",  {29'd0, ovf_w}, 0);
        rst = 1'b1;

        // 4-bit instance: 14*11
        run_op(0, 8'd14, 8'd11, 1'b0, 1'b0, lat, bn, dn);
        chk("n4_out",  get_out(0), 154);
        chk("n4_lat",  lat, 5);
        chk("n4_busy", bn, 5);
        chk("n4_done", dn, 1);
        chk("n4_ovf",  {31'd0, ovf_w[0]}, 0);

        // Default: 255*255, 16 CALC cycles + DONE
        run_op(1, 8'd255, 8'd255, 1'b0, 1'b0, lat, bn, dn);
        chk("ff_out",  get_out(1), 65025);
        chk("ff_lat",  lat, 17);
        chk("ff_done", dn, 1);
        chk("ff_busy", bn, 17);

        // Mode sequence
        run_op(1, 8'd200, 8'd100, 1'b0, 1'b0, lat, bn, dn);
        chk("seq_mul", get_out(1), 20000);
        run_op(1, 8'd50, 8'd3, 1'b1, 1'b0, lat, bn, dn);
        chk("seq_acc", get_out(1), 20150);
        run_op(1, 8'd6, 8'd12, 1'b0, 1'b0, lat, bn, dn);
        chk("seq_clr", get_out(1), 72);

        // 16-bit accumulator: overflow and sticky behaviour
        run_op(2, 8'd255, 8'd255, 1'b0, 1'b0, lat, bn, dn);
        chk("w16_out1", get_out(2), 65025);
        chk("w16_ovf1", {31'd0, ovf_w[2]}, 0);
        run_op(2, 8'd255, 8'd255, 1'b1, 1'b0, lat, bn, dn);
        chk("w16_out2", get_out(2), 64514);
        chk("w16_ovf2", {31'd0, ovf_w[2]}, 1);
        run_op(2, 8'd0, 8'd0, 1'b1, 1'b0, lat, bn, dn);
        chk("w16_zero_out", get_out(2), 64514);
        chk("w16_zero_lat", lat, 17);
        chk("w16_sticky",   {31'd0, ovf_w[2]}, 1);
        run_op(2, 8'd2, 8'd3, 1'b0, 1'b0, lat, bn, dn);
        chk("w16_out3", get_out(2), 6);
        chk("w16_ovf3", {31'd0, ovf_w[2]}, 0);

        // Start pulse during CALC is ignored
        run_op(1, 8'd13, 8'd13, 1'b0, 1'b1, lat, bn, dn);
        chk("ign_out",  get_out(1), 169);
        chk("ign_done", dn, 1);
        chk("ign_lat",  lat, 17);
        repeat (3) @(negedge clk);
        chk("ign_idle", {31'd0, busy_w[1]}, 0);

        // Reset in the middle of an operation
        @(negedge clk);
        st[1] = 1'b1; md[1] = 1'b0; aa[1] = 8'd255; bb[1] = 8'd255;
        @(posedge clk);
        @(negedge clk);
        st[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy_w[1]}, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_out",  get_out(1), 0);
        chk("abort_busy", {31'd0, busy_w[1]}, 0);
        chk("abort_ovf",  {31'd0, ovf_w[1]}, 0);
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_w[1]) dn++;
            @(negedge clk);
        end
        chk("abort_nodone", dn, 0);
        run_op(1, 8'd3, 8'd5, 1'b0, 1'b0, lat, bn, dn);
        chk("post_out", get_out(1), 15);
        chk("post_lat", lat, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
